// File: rtl/mmio_gpio_ctrl.sv
// MMIO GPIO: debounced capture/commit buttons, switch snapshot, staged LEDs; reads combinational, writes/pulses act on the next edge, no backpressure.
// Define MMIO_GPIO_BCD_DECODE_EN to make SW_DATA reads return each snapshot byte converted from packed BCD to binary.
module mmio_gpio_ctrl #(
  parameter int SW_W            = 16,
  parameter int LED_W           = 12,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pread,
  input  logic             pwrite,
  input  logic [2:0]       addr,
  input  logic [31:0]      pwritedata,
  output logic [31:0]      preaddata,
  input  logic             btn_capture,
  input  logic             btn_commit,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_STATUS    = 3'd0;
  localparam logic [2:0] ADDR_LED_STAGE = 3'd1;
  localparam logic [2:0] ADDR_SW_DATA   = 3'd2;
  localparam logic [2:0] ADDR_LED_CUR   = 3'd3;

  // Button lane 0 = capture, lane 1 = commit.
  logic [1:0]       btn_raw;
  logic [1:0]       btn_s1;
  logic [1:0]       btn_s2;
  logic [1:0]       btn_stable;
  logic [1:0]       btn_stable_q;
  logic [1:0]       btn_armed;
  logic [1:0]       btn_pulse;
  logic [CNT_W-1:0] btn_cnt [2];

  logic [SW_W-1:0]  sw_s1;
  logic [SW_W-1:0]  sw_s2;
  logic [SW_W-1:0]  sw_snap;
  logic [SW_W-1:0]  sw_view;
  logic [LED_W-1:0] led_stage;

  logic out_done;
  logic in_valid;
  logic overrun;

  logic cap_pulse;
  logic commit_pulse;
  logic stage_wr;
  logic status_wr;
  logic sw_rd;
  logic wdata_unused;

  assign btn_raw = {btn_commit, btn_capture};

  // A lane only fires after it has seen a debounced release, so a button
  // held through reset must be let go and pressed again.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1       <= '0;
      btn_s2       <= '0;
      btn_stable   <= '0;
      btn_stable_q <= '0;
      btn_armed    <= '0;
      for (int i = 0; i < 2; i++) begin
        btn_cnt[i] <= '0;
      end
    end else begin
      btn_s1       <= btn_raw;
      btn_s2       <= btn_s1;
      btn_stable_q <= btn_stable;
      for (int i = 0; i < 2; i++) begin
        if (btn_s1[i] != btn_s2[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == CNT_MAX) begin
          btn_stable[i] <= btn_s2[i];
          if (!btn_s2[i]) begin
            btn_armed[i] <= 1'b1;
          end
        end else begin
          btn_cnt[i] <= btn_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_pulse    = btn_stable & ~btn_stable_q & btn_armed;
  assign cap_pulse    = btn_pulse[0];
  assign commit_pulse = btn_pulse[1];

  assign stage_wr  = pwrite && (addr == ADDR_LED_STAGE);
  assign status_wr = pwrite && (addr == ADDR_STATUS);
  assign sw_rd     = pread  && (addr == ADDR_SW_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_snap   <= '0;
      led_stage <= '0;
      led       <= '0;
      out_done  <= 1'b0;
      in_valid  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;

      if (cap_pulse) begin
        sw_snap <= sw_s2;
      end

      if (stage_wr) begin
        led_stage <= pwritedata[LED_W-1:0];
      end

      // Commit always takes the pre-write stage value.
      if (commit_pulse) begin
        led <= led_stage;
      end

      if (stage_wr) begin
        out_done <= 1'b0;
      end else if (commit_pulse) begin
        out_done <= 1'b1;
      end else if (status_wr && pwritedata[0]) begin
        out_done <= 1'b0;
      end

      if (cap_pulse) begin
        in_valid <= 1'b1;
      end else if (sw_rd || (status_wr && pwritedata[1])) begin
        in_valid <= 1'b0;
      end

      if (cap_pulse && in_valid && !sw_rd) begin
        overrun <= 1'b1;
      end else if (status_wr && pwritedata[2]) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef MMIO_GPIO_BCD_DECODE_EN
  always_comb begin
    sw_view = sw_snap;
    for (int i = 0; i < SW_W / 8; i++) begin
      sw_view[i*8 +: 8] = ({4'd0, sw_snap[i*8+4 +: 4]} * 8'd10) + {4'd0, sw_snap[i*8 +: 4]};
    end
  end
`else
  assign sw_view = sw_snap;
`endif

  always_comb begin
    preaddata = '0;
    if (pread) begin
      case (addr)
        ADDR_STATUS:    preaddata[2:0]       = {overrun, in_valid, out_done};
        ADDR_LED_STAGE: preaddata[LED_W-1:0] = led_stage;
        ADDR_SW_DATA:   preaddata[SW_W-1:0]  = sw_view;
        ADDR_LED_CUR:   preaddata[LED_W-1:0] = led;
        default:        preaddata            = '0;
      endcase
    end
  end

  assign wdata_unused = ^pwritedata;

endmodule

// File: tb/tb_mmio_gpio_ctrl.sv
// Directed bench for mmio_gpio_ctrl with DEBOUNCE_CYCLES=4, SW_W=16, LED_W=12.
module tb_mmio_gpio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pread;
  logic        pwrite;
  logic [2:0]  addr;
  logic [31:0] pwritedata;
  logic [31:0] preaddata;
  logic        btn_capture;
  logic        btn_commit;
  logic [15:0] sw;
  logic [11:0] led;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

`ifdef MMIO_GPIO_BCD_DECODE_EN
  localparam logic [31:0] EXP_1234 = 32'h0000_0C22;
  localparam logic [31:0] EXP_9999 = 32'h0000_6363;
  localparam logic [31:0] EXP_1111 = 32'h0000_0B0B;
  localparam logic [31:0] EXP_2222 = 32'h0000_1616;
`else
  localparam logic [31:0] EXP_1234 = 32'h0000_1234;
  localparam logic [31:0] EXP_9999 = 32'h0000_9999;
  localparam logic [31:0] EXP_1111 = 32'h0000_1111;
  localparam logic [31:0] EXP_2222 = 32'h0000_2222;
`endif

  mmio_gpio_ctrl #(
    .SW_W(16),
    .LED_W(12),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pread(pread),
    .pwrite(pwrite),
    .addr(addr),
    .pwritedata(pwritedata),
    .preaddata(preaddata),
    .btn_capture(btn_capture),
    .btn_commit(btn_commit),
    .sw(sw),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    addr  = a;
    pread = 1'b1;
    #1;
    d = preaddata;
    tick();
    pread = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    addr       = a;
    pwritedata = d;
    pwrite     = 1'b1;
    tick();
    pwrite = 1'b0;
  endtask

  // Polls STATUS (side-effect free) until all mask bits are set, bounded.
  task automatic wait_bits(input logic [31:0] mask, input string tag);
    logic hit;
    hit   = 1'b0;
    addr  = 3'd0;
    pread = 1'b1;
    for (int n = 0; n < 40 && !hit; n++) begin
      tick();
      if ((preaddata & mask) == mask) hit = 1'b1;
    end
    pread = 1'b0;
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic release_all();
    btn_capture = 1'b0;
    btn_commit  = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet;
    reset       = 1'b1;
    pread       = 1'b0;
    pwrite      = 1'b0;
    addr        = 3'd0;
    pwritedata  = '0;
    btn_capture = 1'b0;
    btn_commit  = 1'b0;
    sw          = 16'h1234;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();

    // Reset state
    check("rst_led", {20'd0, led}, 32'd0);
    cpu_read(3'd0, rd); check("rst_status", rd, 32'd0);
    cpu_read(3'd1, rd); check("rst_stage", rd, 32'd0);
    cpu_read(3'd2, rd); check("rst_swdata", rd, 32'd0);
    cpu_read(3'd3, rd); check("rst_ledcur", rd, 32'd0);
    cpu_read(3'd5, rd); check("rst_addr5", rd, 32'd0);
    addr = 3'd3; #1; check("rd_idle_zero", preaddata, 32'd0);

    // Clean capture: in_valid appears exactly 2+4+1 edges after the press
    addr        = 3'd0;
    pread       = 1'b1;
    btn_capture = 1'b1;
    repeat (6) tick();
    check("cap_lat_early", preaddata, 32'd0);
    tick();
    check("cap_lat", preaddata, 32'd2);
    pread = 1'b0;
    release_all();
    cpu_read(3'd2, rd); check("sw_1234", rd, EXP_1234);
    cpu_read(3'd0, rd); check("rd_clears_inval", rd, 32'd0);

    // Bouncy press gives exactly one capture
    sw = 16'h5678;
    for (int i = 0; i < 6; i++) begin
      btn_capture = (i % 2 == 0);
      tick();
    end
    cpu_read(3'd0, rd); check("bounce_quiet", rd, 32'd0);
    btn_capture = 1'b1;
    repeat (10) tick();
    release_all();
    cpu_read(3'd0, rd); check("bounce_once", rd, 32'd2);

    // Second capture without a read -> overrun; W1C of bit 2 only
    sw          = 16'h9999;
    btn_capture = 1'b1;
    wait_bits(32'd4, "overrun_wait");
    release_all();
    cpu_read(3'd0, rd); check("overrun_set", rd, 32'd6);
    cpu_write(3'd0, 32'd4);
    cpu_read(3'd0, rd); check("w1c_overrun", rd, 32'd2);
    cpu_read(3'd2, rd); check("sw_9999", rd, EXP_9999);
    cpu_read(3'd0, rd); check("status_clear", rd, 32'd0);

    // Stage then commit
    cpu_write(3'd1, 32'hFFFF_FABC);
    check("stage_led_hold", {20'd0, led}, 32'd0);
    cpu_read(3'd1, rd); check("stage_rd", rd, 32'h0000_0ABC);
    cpu_read(3'd0, rd); check("stage_outdone0", rd, 32'd0);
    btn_commit = 1'b1;
    wait_bits(32'd1, "commit_wait");
    check("commit_led", {20'd0, led}, 32'h0000_0ABC);
    cpu_read(3'd3, rd); check("commit_ledcur", rd, 32'h0000_0ABC);
    cpu_read(3'd0, rd); check("commit_status", rd, 32'd1);
    release_all();
    cpu_write(3'd0, 32'd2);
    cpu_read(3'd0, rd); check("w1c_zero_bits", rd, 32'd1);
    cpu_write(3'd0, 32'd1);
    cpu_read(3'd0, rd); check("w1c_outdone", rd, 32'd0);

    // Commit pulse coincident with LED_STAGE write
    btn_commit = 1'b1;
    repeat (6) tick();
    addr       = 3'd1;
    pwritedata = 32'h0000_0055;
    pwrite     = 1'b1;
    tick();
    pwrite = 1'b0;
    check("coinc_led_old", {20'd0, led}, 32'h0000_0ABC);
    cpu_read(3'd1, rd); check("coinc_stage_new", rd, 32'h0000_0055);
    cpu_read(3'd0, rd); check("coinc_outdone0", rd, 32'd0);
    release_all();
    btn_commit = 1'b1;
    wait_bits(32'd1, "commit2_wait");
    check("commit2_led", {20'd0, led}, 32'h0000_0055);
    release_all();

    // Capture pulse coincident with SW_DATA read
    sw          = 16'h1111;
    btn_capture = 1'b1;
    wait_bits(32'd2, "cap3_wait");
    release_all();
    sw          = 16'h2222;
    btn_capture = 1'b1;
    repeat (6) tick();
    addr  = 3'd2;
    pread = 1'b1;
    #1;
    rd = preaddata;
    tick();
    pread = 1'b0;
    check("coinc_rd_old", rd, EXP_1111);
    cpu_read(3'd0, rd); check("coinc_flags", rd & 32'd6, 32'd2);
    release_all();
    cpu_read(3'd2, rd); check("sw_2222", rd, EXP_2222);

    // Reset mid-debounce while the button stays held
    btn_capture = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("rst2_led", {20'd0, led}, 32'd0);
    quiet = 1'b1;
    addr  = 3'd0;
    pread = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (preaddata != 32'd0) quiet = 1'b0;
    end
    pread = 1'b0;
    check("rst2_no_pulse", {31'd0, quiet}, 32'd1);
    release_all();
    cpu_read(3'd2, rd); check("rst2_snap", rd, 32'd0);
    btn_capture = 1'b1;
    wait_bits(32'd2, "rst2_repress");
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_gpio_ctrl.md
# mmio_gpio_ctrl

Parametrised memory-mapped GPIO controller between the CPU peripheral bus and board switches, push-buttons and LEDs. It debounces two buttons, captures switch snapshots on the capture button, and stages CPU-written LED values. Staged values reach the pins only on the commit button. A status register exposes handshake flags with overrun detection and write-1-to-clear semantics.

## Interface
Parameters:
- SW_W, 16, switch width; multiple of 8, 8..32
- LED_W, 12, LED width; 1..32
- DEBOUNCE_CYCLES, 100000, consecutive stable synchronized samples before a button edge is accepted; ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pread  in  1  read strobe
- pwrite  in  1  write strobe
- addr  in  3  word register index
- pwritedata  in  32  write data
- preaddata  out  32  read data, combinational
- btn_capture  in  1  raw button, asynchronous; snapshots switches
- btn_commit  in  1  raw button, asynchronous; drives staged value to LEDs
- sw  in  SW_W  raw switches, asynchronous
- led  out  LED_W  LED drive, registered

## Operation
- Register map:
  - 0 STATUS: RW, W1C. Bit0 out_done, bit1 in_valid, bit2 overrun; other bits read 0.
  - 1 LED_STAGE: RW. Write loads pwritedata[LED_W-1:0]; read returns it zero-extended.
  - 2 SW_DATA: RO, clear-on-read of in_valid. Returns the captured snapshot zero-extended.
  - 3 LED_CUR: RO. Returns current led.
  - 4..7: read 0, writes ignored.
- Each button passes through:
  - a 2-flop synchronizer;
  - a debouncer: a counter resets on any change of the synchronized level; the stable level is updated when the count reaches DEBOUNCE_CYCLES-1;
  - a rising-edge detector on the stable level, producing a 1-cycle pulse.
- sw passes through a 2-flop synchronizer. Capture samples the synchronized value.
- Capture pulse:
  - sw_snap <= synchronized sw; in_valid <= 1.
  - If in_valid was already 1 and there is no same-cycle SW_DATA read: overrun <= 1.
- Commit pulse: led <= LED_STAGE; out_done <= 1.
- CPU write to LED_STAGE: out_done <= 0.
- CPU read of SW_DATA (pread & addr==2): in_valid <= 0 at that clock edge.
- STATUS write: each bit written 1 clears the corresponding flag; bits written 0 leave it unchanged.
- Simultaneous events:
  - Any set event beats a clear (W1C or clear-on-read) of the same flag.
  - LED_STAGE write and commit pulse in the same cycle: led takes the old stage value, stage takes the new value, out_done = 0 (write wins).
- preaddata = 0 whenever pread = 0.
- Reset clears: led = 0, LED_STAGE = 0, sw_snap = 0, all flags = 0, synchronizers and stable levels = 0 (buttons released), debounce counters = 0.

## Timing
- Button pin rising edge to pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES stable cycles. Register and flag effects appear on the following edge.
- Pulses repeat only after a release is debounced and another press is detected; holding a button yields one pulse.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse; counter restarts on each transition.
- Reads are combinational in the pread cycle; writes take effect at the clock edge of the pwrite cycle.
- pread and pwrite in the same cycle: both act independently.
- Reset mid-debounce discards the count; a button still held after reset must be released and pressed again.

## Configuration
- MMIO_GPIO_BCD_DECODE_EN defined: SW_DATA reads convert each captured byte from packed BCD (hi*10+lo, result in the same byte lane, 0..165 for invalid digits, no saturation). Conversion is combinational on read; sw_snap itself stays raw.
- Undefined: SW_DATA returns the raw snapshot.

## Test plan
- Reset: led=0; STATUS, LED_STAGE, SW_DATA and LED_CUR read 0; preaddata=0 with pread low.
- DEBOUNCE_CYCLES=4, sw=16'h1234, clean capture press -> in_valid=1 after 2+4+1 cycles. Raw SW_DATA = 0x1234; with the macro = 0x0C22. The read clears in_valid.
- Capture bounce (1-cycle glitches, then stable) -> exactly one capture. A second capture without a read sets overrun; W1C 0x4 clears it.
- Write LED_STAGE=0xABC -> led unchanged, out_done=0. Commit press -> led=0xABC, out_done=1, LED_CUR=0xABC.
- Commit pulse coincident with LED_STAGE write of 0x055 (stage previously 0xABC) -> led=0xABC, stage=0x055, out_done=0.
- Capture pulse coincident with SW_DATA read -> in_valid stays 1, overrun stays 0. Reset asserted mid-debounce -> no pulse after release of reset.
